sc_bitstream_decoder: RTL and testbench
=======================================

SC_BITSTREAM_DECODER -- requirements
Module: sc_bitstream_decoder

Interface
REQ-001 SHALL have parameter LOG_LEN, default 8; window length is 2^LOG_LEN valid bits, legal range 1..16.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin a decode window.
REQ-005 SHALL have port bit_in, input, 1, stochastic bitstream sample; 1 means the comparator output is one.
REQ-006 SHALL have port bit_valid, input, 1, qualifies bit_in on the current edge.
REQ-007 SHALL have port res, output, 32, decoded unsigned Q0.32 value of the last completed window.
REQ-008 SHALL have port res_valid, output, 1, one-cycle pulse marking a new res.
REQ-009 SHALL have port busy, output, 1, high while a window is accumulating.

Function
REQ-010 SHALL implement FSM states IDLE and ACCUM, registered.
REQ-011 IDLE: on an edge with start=1, SHALL enter ACCUM and clear the ones counter and the valid-bit counter; bit_in is not counted on that edge.
REQ-012 ACCUM: on each edge with bit_valid=1, SHALL increment the valid-bit counter and add bit_in to the ones counter.
REQ-013 ACCUM: on edges with bit_valid=0, SHALL hold both counters; the window stretches, no timeout.
REQ-014 Counters SHALL be LOG_LEN+1 bits wide; the ones count ranges 0..2^LOG_LEN inclusive, with no wrap.
REQ-015 On the edge that samples the 2^LOG_LEN-th valid bit, including that bit in the count, SHALL register res and assert res_valid for exactly the next cycle.
REQ-016 Scaling: res = ones << (32-LOG_LEN); if ones = 2^LOG_LEN, res SHALL saturate to 32'hFFFF_FFFF.
REQ-017 res SHALL hold its value until the next window completes; res_valid low otherwise.
REQ-018 On the completion edge, if start=0 the FSM SHALL return to IDLE; if start=1 it SHALL stay in ACCUM with counters cleared, starting a back-to-back window with no gap cycle.
REQ-019 start during ACCUM, other than on the completion edge, SHALL be ignored.
REQ-020 busy SHALL equal (state == ACCUM).
REQ-021 bit_in and bit_valid in IDLE SHALL be ignored.
REQ-022 Latency: the first res_valid SHALL occur one cycle after the edge sampling the last valid bit; with continuous bit_valid this is 2^LOG_LEN+1 cycles after the start edge.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, counters=0, res=0, res_valid=0, busy=0.
REQ-024 Reset asserted mid-window SHALL discard the partial window; no res_valid SHALL be produced for it.
REQ-025 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification (LOG_LEN=4, window 16 bits)
REQ-026 All-ones window: start pulse, 16 cycles bit_valid=1, bit_in=1 -> res=32'hFFFF_FFFF, single res_valid pulse, busy low afterward.
REQ-027 All-zeros window -> res=32'h0000_0000, res_valid pulses once; alternating 1/0 window (8 ones) -> res=32'h8000_0000.
REQ-028 Stalled stream: 3 ones among 16 valid bits with bit_valid=0 gaps of random length -> res=32'h3000_0000; res_valid occurs one cycle after the 16th valid bit only.
REQ-029 Back-to-back: start held high through two windows, 16 ones then 4 ones -> res=FFFF_FFFF then 4000_0000; busy stays high with no gap; exactly two res_valid pulses.
REQ-030 Reset mid-window: rst_n low after 10 valid bits -> outputs 0 asynchronously, no res_valid; a new start window of 5 ones -> res=32'h5000_0000.

Source files
------------

// File: rtl/sc_bitstream_decoder.sv
// Stochastic-computing bitstream decoder: counts ones over a window of 2^LOG_LEN
// valid bits and reports the fraction as an unsigned Q0.32 value.
module sc_bitstream_decoder #(
  parameter int LOG_LEN = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic [31:0] res,
  output logic        res_valid,
  output logic        busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [LOG_LEN:0] CNT_ONE  = (LOG_LEN+1)'(1);
  localparam logic [LOG_LEN:0] LAST_IDX = (LOG_LEN+1)'((1 << LOG_LEN) - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LOG_LEN:0] r_cnt;
  logic [LOG_LEN:0] r_ones;
  logic [31:0]      r_res;
  logic             r_res_valid;
  logic [LOG_LEN:0] w_cnt_inc;
  logic [LOG_LEN:0] w_ones_inc;
  logic             w_done;

  // A full window of ones cannot be shifted into Q0.32, so it saturates to all-ones.
  function automatic logic [31:0] scale_q032(input logic [LOG_LEN:0] ones);
    logic [31:0] v;
    v = 32'(ones[LOG_LEN-1:0]);
    if (ones[LOG_LEN])
      return 32'hFFFF_FFFF;
    return v << (32 - LOG_LEN);
  endfunction

  assign w_cnt_inc  = r_cnt + CNT_ONE;
  assign w_ones_inc = r_ones + {{LOG_LEN{1'b0}}, bit_in};
  assign w_done     = (r_state == ACCUM) && bit_valid && (r_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = ACCUM;
      ACCUM:   if (w_done && !start) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counters clear on a window start or completion; otherwise advance only on valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_ones      <= '0;
      r_res       <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= w_done;
      if (r_state == IDLE) begin
        if (start) begin
          r_cnt  <= '0;
          r_ones <= '0;
        end
      end else if (bit_valid) begin
        if (w_done) begin
          r_res  <= scale_q032(w_ones_inc);
          r_cnt  <= '0;
          r_ones <= '0;
        end else begin
          r_cnt  <= w_cnt_inc;
          r_ones <= w_ones_inc;
        end
      end
    end
  end

  assign res       = r_res;
  assign res_valid = r_res_valid;
  assign busy      = (r_state == ACCUM);

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// Directed bench for sc_bitstream_decoder (LOG_LEN=4) with a result scoreboard.
module tb_sc_bitstream_decoder;

  localparam int LOG_LEN = 4;
  localparam int WIN     = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        bit_in;
  logic        bit_valid;
  logic [31:0] res;
  logic        res_valid;
  logic        busy;

  int          n_cmp   = 0;
  int          n_fail  = 0;
  int          n_pulse = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  sc_bitstream_decoder #(.LOG_LEN(LOG_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .res       (res),
    .res_valid (res_valid),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every res_valid cycle must match the oldest expected result.
  always @(negedge clk) begin
    logic [31:0] e;
    if (res_valid) begin
      n_pulse++;
      if (sb.size() == 0) begin
        chk("unexpected_res_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("res", res, e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    step();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_window(input string tag, input logic [15:0] pat, input logic [31:0] exp);
    int p0;
    p0 = n_pulse;
    sb.push_back(exp);
    start_pulse();
    chk({tag, "_busy_on"}, 32'(busy), 32'd1);
    for (int i = 0; i < WIN - 1; i++) send_bit(pat[i]);
    chk({tag, "_no_early_valid"}, 32'(res_valid), 32'd0);
    send_bit(pat[WIN-1]);
    chk({tag, "_latency_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    step();
    step();
    chk({tag, "_pulses"}, 32'(n_pulse - p0), 32'd1);
    chk({tag, "_res_hold"}, res, exp);
    chk({tag, "_valid_low"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    int p0;
    int gap;
    logic [15:0] pat;

    rst_n = 1'b0; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    #2;
    chk("rst_res", res, 32'h0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Bits offered in IDLE must be ignored
    bit_valid = 1'b1; bit_in = 1'b1;
    repeat (4) step();
    bit_valid = 1'b0; bit_in = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);

    run_window("ones", 16'hFFFF, 32'hFFFF_FFFF);
    run_window("zeros", 16'h0000, 32'h0000_0000);
    run_window("alt", 16'h5555, 32'h8000_0000);

    // Stalled stream: 3 ones, random gaps, spurious start mid-window
    p0 = n_pulse;
    sb.push_back(32'h3000_0000);
    start_pulse();
    pat = 16'h2084;
    for (int i = 0; i < WIN; i++) begin
      gap = int'($urandom_range(0, 3));
      if (i == WIN - 1) gap = 3;
      for (int g = 0; g < gap; g++) begin
        bit_in = 1'($urandom_range(0, 1));
        step();
        if (i == WIN - 1) chk("stall_no_early_valid", 32'(res_valid), 32'd0);
      end
      bit_in = 1'b0;
      if (i == 5) start = 1'b1;
      send_bit(pat[i]);
      start = 1'b0;
    end
    chk("stall_latency_valid", 32'(res_valid), 32'd1);
    chk("stall_busy_off", 32'(busy), 32'd0);
    step();
    step();
    chk("stall_pulses", 32'(n_pulse - p0), 32'd1);

    // Back-to-back windows with start held across the first completion
    p0 = n_pulse;
    sb.push_back(32'hFFFF_FFFF);
    sb.push_back(32'h4000_0000);
    start = 1'b1;
    step();
    for (int i = 0; i < WIN; i++) send_bit(1'b1);
    chk("b2b_first_valid", 32'(res_valid), 32'd1);
    chk("b2b_busy_kept", 32'(busy), 32'd1);
    start = 1'b0;
    pat = 16'h8421;
    for (int i = 0; i < WIN; i++) begin
      send_bit(pat[i]);
      if (i == 0) chk("b2b_busy_second", 32'(busy), 32'd1);
    end
    chk("b2b_second_valid", 32'(res_valid), 32'd1);
    chk("b2b_busy_off", 32'(busy), 32'd0);
    step();
    step();
    chk("b2b_pulses", 32'(n_pulse - p0), 32'd2);

    // Reset mid-window discards the partial window
    p0 = n_pulse;
    start_pulse();
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    rst_n = 1'b0;
    #2;
    chk("midrst_res", res, 32'h0);
    chk("midrst_valid", 32'(res_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    bit_valid = 1'b1; bit_in = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (6) step();
    bit_valid = 1'b0; bit_in = 1'b0;
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_pulses", 32'(n_pulse - p0), 32'd0);
    run_window("five", 16'h001F, 32'h5000_0000);

    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
